raster_frame_scheduler: RTL
===========================

RASTER_FRAME_SCHEDULER -- requirements
Module: raster_frame_scheduler

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- FB_WIDTH, 320, framebuffer width in pixels
- FB_HEIGHT, 180, framebuffer height in pixels
- DEPTH_BIT_WIDTH, 16, depth word width
- TRI_IDX_WIDTH, 8, triangle index width
- TIMEOUT_CYCLES, 65536, max WAIT cycles per triangle
REQ-002 SHALL derive ADDR_WIDTH = $clog2(FB_WIDTH*FB_HEIGHT).
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk_in, in, 1, single clock; all logic on rising edge
- rst_n_in, in, 1, reset, asynchronous and active-low
- frame_start, in, 1, request one frame; level sampled in IDLE only
- num_tris, in, TRI_IDX_WIDTH, triangles in frame; latched on accept
- vsync_in, in, 1, buffer swap permitted while high
- raster_busy, in, 1, rasterizer busy
- raster_done, in, 1, rasterizer one-cycle done pulse
- raster_start, out, 1, one-cycle start pulse to rasterizer
- tri_idx, out, TRI_IDX_WIDTH, index of triangle being drawn
- clear_we, out, 1, depth-buffer clear write enable
- clear_addr, out, ADDR_WIDTH, clear write address
- clear_depth, out, DEPTH_BIT_WIDTH, clear value, constant all-ones (far)
- draw_buf_sel, out, 1, back buffer being rendered
- disp_buf_sel, out, 1, front buffer being scanned; always ~draw_buf_sel
- busy, out, 1, high from accept until frame_done
- frame_done, out, 1, one-cycle end-of-frame pulse
- timeout_err, out, 1, sticky watchdog flag
- sched_state, out, 3, state encoding for debug

Function
REQ-004 SHALL register all outputs; state encoding: IDLE=0, CLEAR=1, ISSUE=2, WAIT=3, SWAP=4, DONE=5.
REQ-005 IDLE: frame_start=1 SHALL latch num_tris, set busy=1, set tri_idx=0, clear timeout_err, and move to CLEAR next cycle.
REQ-006 frame_start SHALL be ignored in every state other than IDLE; there is no queueing.
REQ-007 CLEAR SHALL assert clear_we for exactly FB_WIDTH*FB_HEIGHT consecutive cycles, with clear_addr = 0,1,...,FB_WIDTH*FB_HEIGHT-1, one address per cycle.
REQ-008 After the last address, the block SHALL go to ISSUE if latched num_tris != 0, else to SWAP; clear_we SHALL be 0 outside CLEAR.
REQ-009 ISSUE SHALL stall while raster_busy=1; when raster_busy=0 it SHALL pulse raster_start for exactly one cycle and enter WAIT.
REQ-010 WAIT SHALL run a watchdog counter, zeroed on WAIT entry.
REQ-011 In WAIT, raster_done=1 SHALL end the triangle.
REQ-012 In WAIT, a counter reaching TIMEOUT_CYCLES-1 without raster_done SHALL set timeout_err=1 and end the triangle; if both occur in the same cycle, raster_done wins and timeout_err is not set.
REQ-013 Ending a triangle: if tri_idx == num_tris-1, go to SWAP with tri_idx held; else increment tri_idx and go to ISSUE.
REQ-014 raster_done outside WAIT SHALL be ignored.
REQ-015 SWAP SHALL wait for vsync_in=1. On that cycle it SHALL toggle draw_buf_sel, keep disp_buf_sel = ~draw_buf_sel, and go to DONE.
REQ-016 DONE SHALL pulse frame_done=1 and set busy=0 for one cycle, then return to IDLE.
REQ-017 A frame_start held high SHALL be accepted again in the first IDLE cycle after DONE.
REQ-018 tri_idx arithmetic SHALL be unsigned TRI_IDX_WIDTH.
REQ-019 num_tris = 2^TRI_IDX_WIDTH-1 SHALL draw indices 0..2^TRI_IDX_WIDTH-2; tri_idx SHALL never wrap.

Reset
REQ-020 rst_n_in=0 SHALL, asynchronously and regardless of state (including mid-CLEAR or mid-WAIT), force:
- state IDLE
- raster_start, clear_we, busy, frame_done, timeout_err = 0
- clear_addr, tri_idx = 0
- draw_buf_sel=0, disp_buf_sel=1
REQ-021 clear_depth SHALL be all-ones in and out of reset.
REQ-022 Release SHALL be acted on at the first clock edge with rst_n_in=1; no pulse SHALL be emitted on reset exit.

Verification (bench params FB_WIDTH=4, FB_HEIGHT=2, TIMEOUT_CYCLES=16)
REQ-023 frame_start, num_tris=3, rasterizer model done 5 cycles after start, vsync_in=1 -> 8 clear writes at addr 0..7; 3 raster_start pulses with tri_idx 0,1,2; draw_buf_sel 0->1; one frame_done; timeout_err=0.
REQ-024 num_tris=0 -> 8 clear writes, no raster_start, swap, then frame_done.
REQ-025 raster_done never returned, num_tris=2 -> each WAIT lasts 16 cycles; timeout_err=1; frame still completes.
REQ-026 raster_busy held high 10 cycles after CLEAR, then frame_start pulsed mid-frame -> raster_start delayed until busy low; mid-frame frame_start has no effect.
REQ-027 vsync_in low for 20 cycles after last triangle -> sched_state=4 for 20 cycles; swap and frame_done follow vsync_in rise.
REQ-028 rst_n_in asserted at clear_addr=3 -> all outputs at reset values immediately, without waiting for a clock edge; next frame_start restarts clear at addr 0.

Source files
------------

// File: rtl/raster_frame_scheduler.sv
// Frame sequencer for a tile-less rasterizer: clears depth, issues triangles one at a time
// with a per-triangle watchdog, then swaps front/back buffers on vsync.
`timescale 1ns/1ps
module raster_frame_scheduler #(
  parameter int unsigned FB_WIDTH        = 320,
  parameter int unsigned FB_HEIGHT       = 180,
  parameter int unsigned DEPTH_BIT_WIDTH = 16,
  parameter int unsigned TRI_IDX_WIDTH   = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 65536,
  localparam int unsigned ADDR_WIDTH     = $clog2(FB_WIDTH * FB_HEIGHT)
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       frame_start,
  input  logic [TRI_IDX_WIDTH-1:0]   num_tris,
  input  logic                       vsync_in,
  input  logic                       raster_busy,
  input  logic                       raster_done,
  output logic                       raster_start,
  output logic [TRI_IDX_WIDTH-1:0]   tri_idx,
  output logic                       clear_we,
  output logic [ADDR_WIDTH-1:0]      clear_addr,
  output logic [DEPTH_BIT_WIDTH-1:0] clear_depth,
  output logic                       draw_buf_sel,
  output logic                       disp_buf_sel,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       timeout_err,
  output logic [2:0]                 sched_state
);

  localparam int unsigned WdWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT - 1);
  localparam logic [WdWidth-1:0]    WdLast   = WdWidth'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StIssue = 3'd2,
    StWait  = 3'd3,
    StSwap  = 3'd4,
    StDone  = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [TRI_IDX_WIDTH-1:0] num_tris_q, num_tris_d;
  logic [TRI_IDX_WIDTH-1:0] tri_idx_q, tri_idx_d;
  logic [ADDR_WIDTH-1:0]    clear_addr_q, clear_addr_d;
  logic [WdWidth-1:0]       wd_cnt_q, wd_cnt_d;
  logic clear_we_q, clear_we_d;
  logic raster_start_q, raster_start_d;
  logic busy_q, busy_d;
  logic frame_done_q, frame_done_d;
  logic timeout_err_q, timeout_err_d;
  logic draw_buf_q, draw_buf_d;

  logic clear_last, wd_expired, tri_end, last_tri;

  assign clear_last = (clear_addr_q == LastAddr);
  assign wd_expired = (wd_cnt_q == WdLast);
  // raster_done takes priority, so a coincident expiry does not flag an error
  assign tri_end    = raster_done || wd_expired;
  assign last_tri   = (tri_idx_q == (num_tris_q - TRI_IDX_WIDTH'(1)));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (frame_start) state_d = StClear;
      StClear: if (clear_last) state_d = (num_tris_q != '0) ? StIssue : StSwap;
      StIssue: if (!raster_busy) state_d = StWait;
      StWait:  if (tri_end) state_d = last_tri ? StSwap : StIssue;
      StSwap:  if (vsync_in) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    num_tris_d     = num_tris_q;
    tri_idx_d      = tri_idx_q;
    clear_addr_d   = clear_addr_q;
    wd_cnt_d       = wd_cnt_q;
    timeout_err_d  = timeout_err_q;
    busy_d         = busy_q;
    draw_buf_d     = draw_buf_q;
    clear_we_d     = (state_d == StClear);
    frame_done_d   = (state_d == StDone);
    raster_start_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (frame_start) begin
          num_tris_d    = num_tris;
          busy_d        = 1'b1;
          tri_idx_d     = '0;
          timeout_err_d = 1'b0;
          clear_addr_d  = '0;
        end
      end
      StClear: begin
        if (!clear_last) clear_addr_d = clear_addr_q + ADDR_WIDTH'(1);
      end
      StIssue: begin
        if (!raster_busy) begin
          raster_start_d = 1'b1;
          wd_cnt_d       = '0;
        end
      end
      StWait: begin
        if (tri_end) begin
          if (!raster_done) timeout_err_d = 1'b1;
          if (!last_tri) tri_idx_d = tri_idx_q + TRI_IDX_WIDTH'(1);
        end else begin
          wd_cnt_d = wd_cnt_q + WdWidth'(1);
        end
      end
      StSwap: begin
        if (vsync_in) begin
          draw_buf_d = ~draw_buf_q;
          busy_d     = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      num_tris_q     <= '0;
      tri_idx_q      <= '0;
      clear_addr_q   <= '0;
      wd_cnt_q       <= '0;
      clear_we_q     <= 1'b0;
      raster_start_q <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      timeout_err_q  <= 1'b0;
      draw_buf_q     <= 1'b0;
    end else begin
      num_tris_q     <= num_tris_d;
      tri_idx_q      <= tri_idx_d;
      clear_addr_q   <= clear_addr_d;
      wd_cnt_q       <= wd_cnt_d;
      clear_we_q     <= clear_we_d;
      raster_start_q <= raster_start_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      timeout_err_q  <= timeout_err_d;
      draw_buf_q     <= draw_buf_d;
    end
  end

  assign raster_start = raster_start_q;
  assign tri_idx      = tri_idx_q;
  assign clear_we     = clear_we_q;
  assign clear_addr   = clear_addr_q;
  assign clear_depth  = '1;
  assign draw_buf_sel = draw_buf_q;
  assign disp_buf_sel = ~draw_buf_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign timeout_err  = timeout_err_q;
  assign sched_state  = state_q;

endmodule
